video_timing_gen: RTL and testbench

- Synthesizable, parametrised successor to the simulation-only HDMI stimulus generator.
- Produces DE/HSYNC/VSYNC timing for any raster, with programmable sync polarity.
- Issues pixel requests with X/Y coordinates to an upstream frame source.
- Re-aligns the returned RGB with the timing through a fixed-latency delay line.
- Supports frame-boundary start/stop and flags pixel underflow. It sits between the frame buffer/pattern source and the HDMI/VGA encoder on the Zybo.

---
 rtl/video_pkg.sv | 45 ++++
 rtl/video_timing_gen_if.sv | 22 ++
 rtl/video_delay_line.sv | 28 ++
 rtl/video_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared types and raster constants for the video timing generator.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } pol_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vtg_state_e;

  // 640x480@60 raster
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Small 64x64 raster for simulation
  localparam int unsigned TST_H_ACTIVE = 64;
  localparam int unsigned TST_H_FP     = 8;
  localparam int unsigned TST_H_SYNC   = 2;
  localparam int unsigned TST_H_BP     = 8;
  localparam int unsigned TST_V_ACTIVE = 64;
  localparam int unsigned TST_V_FP     = 2;
  localparam int unsigned TST_V_SYNC   = 4;
  localparam int unsigned TST_V_BP     = 8;

  // Pin level for a sync pulse given its polarity and whether it is asserted.
  function automatic logic sync_level(pol_e pol, logic asserted);
    return asserted ? logic'(pol) : ~logic'(pol);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel request / return bus between the timing generator and the frame source.
interface video_timing_gen_if
  import video_pkg::*;
#(
  parameter int unsigned CNT_W = 12
);
  logic             pix_req;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             pix_valid;
  rgb_t             pix_data;

  modport master (
    output pix_req, pix_x, pix_y,
    input  pix_valid, pix_data
  );

  modport slave (
    input  pix_req, pix_x, pix_y,
    output pix_valid, pix_data
  );
endinterface

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with async reset, used to align timing with pixel data.
module video_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  // Shift one stage per clock; reset flushes every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: issues pixel requests and re-aligns returned RGB
// with DE/HSYNC/VSYNC through a PIX_LAT+1 cycle pipeline.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter pol_e        HS_POL   = POL_LOW,
  parameter pol_e        VS_POL   = POL_LOW,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned PIX_LAT  = 2,
  parameter rgb_t        DEF_RGB  = 24'h000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  video_timing_gen_if.master        pix,
  output logic                      frame_start,
  output logic                      hdmi_de,
  output logic                      hdmi_hs,
  output logic                      hdmi_vs,
  output logic [7:0]                hdmi_r,
  output logic [7:0]                hdmi_g,
  output logic [7:0]                hdmi_b,
  output logic                      underflow
);

  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  vtg_state_e       state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             last_col_c, last_pix_c;
  logic             req_d, fs_d, hs_d, vs_d;

  logic             req_q, fs_q, hs_raw_q, vs_raw_q;
  logic [CNT_W-1:0] x_q, y_q;

  logic [2:0]       tim_dl;
  logic             de_dl, hs_dl, vs_dl;
  rgb_t             rgb_q;
  logic             de_q, hs_q, vs_q, uf_q;

  // Next state, counter advance, and next-cycle request/sync decode.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    last_col_c = (hcnt_q == CNT_W'(H_TOT - 1));
    last_pix_c = last_col_c && (vcnt_q == CNT_W'(V_TOT - 1));
    req_d      = 1'b0;
    fs_d       = 1'b0;
    hs_d       = 1'b0;
    vs_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_pix_c) begin
          hcnt_d = '0;
          vcnt_d = '0;
          if (!en) state_d = ST_IDLE;
        end else if (last_col_c) begin
          hcnt_d = '0;
          vcnt_d = vcnt_q + CNT_W'(1);
        end else begin
          hcnt_d = hcnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_RUN) begin
      req_d = (hcnt_d < CNT_W'(H_ACTIVE)) && (vcnt_d < CNT_W'(V_ACTIVE));
      fs_d  = (hcnt_d == '0) && (vcnt_d == '0);
      hs_d  = (hcnt_d >= CNT_W'(HS_START)) && (hcnt_d < CNT_W'(HS_END));
      vs_d  = (vcnt_d >= CNT_W'(VS_START)) && (vcnt_d < CNT_W'(VS_END));
    end
  end

  // State, counters and pre-delay request/timing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      req_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      fs_q     <= 1'b0;
      hs_raw_q <= 1'b0;
      vs_raw_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      req_q    <= req_d;
      x_q      <= req_d ? hcnt_d : '0;
      y_q      <= req_d ? vcnt_d : '0;
      fs_q     <= fs_d;
      hs_raw_q <= hs_d;
      vs_raw_q <= vs_d;
    end
  end

  assign pix.pix_req = req_q;
  assign pix.pix_x   = x_q;
  assign pix.pix_y   = y_q;
  assign frame_start = fs_q;

  video_delay_line #(
    .DEPTH (PIX_LAT),
    .WIDTH (3)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  ({req_q, hs_raw_q, vs_raw_q}),
    .dout (tim_dl)
  );

  assign {de_dl, hs_dl, vs_dl} = tim_dl;

  // Final stage: merge returned colour with aligned timing; substitute on underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q  <= 1'b0;
      hs_q  <= sync_level(HS_POL, 1'b0);
      vs_q  <= sync_level(VS_POL, 1'b0);
      rgb_q <= '0;
    end else begin
      de_q <= de_dl;
      hs_q <= sync_level(HS_POL, hs_dl);
      vs_q <= sync_level(VS_POL, vs_dl);
      if (!de_dl)             rgb_q <= '0;
      else if (pix.pix_valid) rgb_q <= pix.pix_data;
      else                    rgb_q <= DEF_RGB;
    end
  end

  // Sticky underflow flag; a new miss wins over the frame-start clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          uf_q <= 1'b0;
    else if (de_dl && !pix.pix_valid) uf_q <= 1'b1;
    else if (fs_q)                    uf_q <= 1'b0;
  end

  assign hdmi_de   = de_q;
  assign hdmi_hs   = hs_q;
  assign hdmi_vs   = vs_q;
  assign hdmi_r    = rgb_q.r;
  assign hdmi_g    = rgb_q.g;
  assign hdmi_b    = rgb_q.b;
  assign underflow = uf_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on the 64x64 raster: three instances
// (latency 2 / pol low, latency 1 / pol high, latency 8 / pol low).
module tb_video_timing_gen;
  import video_pkg::*;

  localparam int HA = 64, HF = 8, HSY = 2, HB = 8;
  localparam int VA = 64, VF = 2, VSY = 4, VB = 8;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int TOT = HT * VT;
  localparam int NDUT = 3;
  localparam int HD = 10;
  localparam rgb_t DEF0 = 24'hA5C33C;

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 8;
  endfunction
  function automatic bit pol_of(int i);
    return (i == 1);
  endfunction
  function automatic int def_of(int i);
    return (i == 0) ? int'(DEF0) : 0;
  endfunction

  logic clk = 1'b0;
  logic rst, en0;
  logic en_on = 1'b1;

  video_timing_gen_if #(.CNT_W(12)) pif0 ();
  video_timing_gen_if #(.CNT_W(12)) pif1 ();
  video_timing_gen_if #(.CNT_W(12)) pif2 ();

  logic        fs [NDUT], de [NDUT], hs [NDUT], vs [NDUT], uf [NDUT], req [NDUT];
  logic [7:0]  r [NDUT], g [NDUT], b [NDUT];
  logic [11:0] px [NDUT], py [NDUT];
  logic        pv [NDUT];
  rgb_t        pd [NDUT];

  assign pif0.pix_valid = pv[0]; assign pif0.pix_data = pd[0];
  assign pif1.pix_valid = pv[1]; assign pif1.pix_data = pd[1];
  assign pif2.pix_valid = pv[2]; assign pif2.pix_data = pd[2];
  assign req[0] = pif0.pix_req; assign px[0] = pif0.pix_x; assign py[0] = pif0.pix_y;
  assign req[1] = pif1.pix_req; assign px[1] = pif1.pix_x; assign py[1] = pif1.pix_y;
  assign req[2] = pif2.pix_req; assign px[2] = pif2.pix_x; assign py[2] = pif2.pix_y;

  video_timing_gen #(
    .H_ACTIVE(TST_H_ACTIVE), .H_FP(TST_H_FP), .H_SYNC(TST_H_SYNC), .H_BP(TST_H_BP),
    .V_ACTIVE(TST_V_ACTIVE), .V_FP(TST_V_FP), .V_SYNC(TST_V_SYNC), .V_BP(TST_V_BP),
    .HS_POL(POL_LOW), .VS_POL(POL_LOW), .CNT_W(12), .PIX_LAT(2), .DEF_RGB(DEF0)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en0), .pix(pif0), .frame_start(fs[0]),
    .hdmi_de(de[0]), .hdmi_hs(hs[0]), .hdmi_vs(vs[0]),
    .hdmi_r(r[0]), .hdmi_g(g[0]), .hdmi_b(b[0]), .underflow(uf[0])
  );

  video_timing_gen #(
    .H_ACTIVE(TST_H_ACTIVE), .H_FP(TST_H_FP), .H_SYNC(TST_H_SYNC), .H_BP(TST_H_BP),
    .V_ACTIVE(TST_V_ACTIVE), .V_FP(TST_V_FP), .V_SYNC(TST_V_SYNC), .V_BP(TST_V_BP),
    .HS_POL(POL_HIGH), .VS_POL(POL_HIGH), .CNT_W(12), .PIX_LAT(1), .DEF_RGB(24'h000000)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en_on), .pix(pif1), .frame_start(fs[1]),
    .hdmi_de(de[1]), .hdmi_hs(hs[1]), .hdmi_vs(vs[1]),
    .hdmi_r(r[1]), .hdmi_g(g[1]), .hdmi_b(b[1]), .underflow(uf[1])
  );

  video_timing_gen #(
    .H_ACTIVE(TST_H_ACTIVE), .H_FP(TST_H_FP), .H_SYNC(TST_H_SYNC), .H_BP(TST_H_BP),
    .V_ACTIVE(TST_V_ACTIVE), .V_FP(TST_V_FP), .V_SYNC(TST_V_SYNC), .V_BP(TST_V_BP),
    .HS_POL(POL_LOW), .VS_POL(POL_LOW), .CNT_W(12), .PIX_LAT(8), .DEF_RGB(24'h000000)
  ) dut2 (
    .clk(clk), .rst(rst), .en(en_on), .pix(pif2), .frame_start(fs[2]),
    .hdmi_de(de[2]), .hdmi_hs(hs[2]), .hdmi_vs(vs[2]),
    .hdmi_r(r[2]), .hdmi_g(g[2]), .hdmi_b(b[2]), .underflow(uf[2])
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a linear position within the frame plus a history of what
  // each past cycle should have requested, keyed by age in cycles.
  bit  m_run [NDUT];
  int  m_pos [NDUT];
  bit  m_uf  [NDUT];
  bit  h_de [NDUT][HD], h_hs [NDUT][HD], h_vs [NDUT][HD], h_fs [NDUT][HD], h_drop [NDUT][HD];
  int  h_x  [NDUT][HD], h_y [NDUT][HD];
  bit  s_req [NDUT][HD];
  logic [11:0] s_x [NDUT][HD], s_y [NDUT][HD];
  bit  drop_tgt = 1'b0, drop_rand = 1'b0;
  int  cnt_de, run_len, max_run, rises;

  function automatic void chk(string nm, int i, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_run[i] = 1'b0; m_pos[i] = 0; m_uf[i] = 1'b0;
      for (int k = 0; k < HD; k++) begin
        h_de[i][k] = 0; h_hs[i][k] = 0; h_vs[i][k] = 0; h_fs[i][k] = 0; h_drop[i][k] = 0;
        h_x[i][k] = 0; h_y[i][k] = 0; s_req[i][k] = 0; s_x[i][k] = '0; s_y[i][k] = '0;
      end
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  endtask

  task automatic check_all();
    int a, hx, hy, e_rgb;
    for (int i = 0; i < NDUT; i++) begin
      a  = lat_of(i) + 1;
      hx = h_x[i][a]; hy = h_y[i][a];
      chk("pix_req", i, int'(req[i]), int'(h_de[i][0]));
      chk("pix_x", i, int'(px[i]), h_de[i][0] ? h_x[i][0] : 0);
      chk("pix_y", i, int'(py[i]), h_de[i][0] ? h_y[i][0] : 0);
      chk("frame_start", i, int'(fs[i]), int'(h_fs[i][0]));
      chk("hdmi_de", i, int'(de[i]), int'(h_de[i][a]));
      chk("hdmi_hs", i, int'(hs[i]), int'(h_hs[i][a] ? pol_of(i) : !pol_of(i)));
      chk("hdmi_vs", i, int'(vs[i]), int'(h_vs[i][a] ? pol_of(i) : !pol_of(i)));
      e_rgb = !h_de[i][a] ? 0 : h_drop[i][a] ? def_of(i) : ((hx << 16) | (hy << 8) | (hx ^ hy));
      chk("rgb", i, int'({r[i], g[i], b[i]}), e_rgb);
      chk("underflow", i, int'(uf[i]), int'(m_uf[i]));
    end
  endtask

  // One clock: advance model and source, then compare everything 1 time unit after the edge.
  task automatic step();
    bit en_s [NDUT];
    int hh, vv, l;
    for (int i = 0; i < NDUT; i++) en_s[i] = (i == 0) ? en0 : 1'b1;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        l = lat_of(i);
        if (!m_run[i]) begin
          if (en_s[i]) begin m_run[i] = 1'b1; m_pos[i] = 0; end
        end else if (m_pos[i] == TOT - 1) begin
          m_pos[i] = 0;
          if (!en_s[i]) m_run[i] = 1'b0;
        end else begin
          m_pos[i]++;
        end
        for (int k = HD - 1; k > 0; k--) begin
          h_de[i][k] = h_de[i][k-1]; h_hs[i][k] = h_hs[i][k-1]; h_vs[i][k] = h_vs[i][k-1];
          h_fs[i][k] = h_fs[i][k-1]; h_drop[i][k] = h_drop[i][k-1];
          h_x[i][k] = h_x[i][k-1]; h_y[i][k] = h_y[i][k-1];
          s_req[i][k] = s_req[i][k-1]; s_x[i][k] = s_x[i][k-1]; s_y[i][k] = s_y[i][k-1];
        end
        hh = m_pos[i] % HT;
        vv = m_pos[i] / HT;
        h_de[i][0] = m_run[i] && hh < HA && vv < VA;
        h_hs[i][0] = m_run[i] && hh >= HA + HF && hh < HA + HF + HSY;
        h_vs[i][0] = m_run[i] && vv >= VA + VF && vv < VA + VF + VSY;
        h_fs[i][0] = m_run[i] && m_pos[i] == 0;
        h_x[i][0]  = hh;
        h_y[i][0]  = vv;
        h_drop[i][0] = h_de[i][0] && (i == 0) &&
                       ((drop_tgt && hh == 5 && vv == 3) || (drop_rand && $urandom_range(0, 99) < 3));
        if (h_de[i][l+1] && h_drop[i][l+1]) m_uf[i] = 1'b1;
        else if (h_fs[i][1])                m_uf[i] = 1'b0;
        s_req[i][0] = req[i]; s_x[i][0] = px[i]; s_y[i][0] = py[i];
        pv[i] = s_req[i][l] && !h_drop[i][l];
        pd[i] = s_req[i][l] ? rgb_t'({s_x[i][l][7:0], s_y[i][l][7:0], s_x[i][l][7:0] ^ s_y[i][l][7:0]})
                            : rgb_t'(24'h0);
      end
    end
    check_all();
    if (de[0]) begin
      cnt_de++; run_len++;
      if (run_len > max_run) max_run = run_len;
      if (run_len == 1) rises++;
    end else begin
      run_len = 0;
    end
  endtask

  task automatic wait_fs();
    for (int n = 0; n < TOT + 16 && !fs[0]; n++) step();
    chk("fs_wait", 0, int'(fs[0]), 1);
  endtask

  typedef struct {
    int          off;
    bit          de;
    bit          hs;
    bit          vs;
    logic [23:0] rgb;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  int cur;
  bit seen_fs, seen_req;

  initial begin
    // Landmarks of the first frame of dut0, as offsets from its frame_start cycle.
    tbl[0]  = '{0,    1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[1]  = '{3,    1'b1, 1'b1, 1'b1, 24'h000000};
    tbl[2]  = '{66,   1'b1, 1'b1, 1'b1, 24'h3F003F};
    tbl[3]  = '{67,   1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[4]  = '{74,   1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[5]  = '{75,   1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[6]  = '{76,   1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[7]  = '{77,   1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[8]  = '{90,   1'b1, 1'b1, 1'b1, 24'h050104};
    tbl[9]  = '{5232, 1'b1, 1'b1, 1'b1, 24'h3F3F00};
    tbl[10] = '{5414, 1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[11] = '{5415, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[12] = '{5742, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[13] = '{5743, 1'b0, 1'b1, 1'b1, 24'h000000};

    rst = 1'b1; en0 = 1'b0;
    model_reset();
    repeat (3) step();
    rst = 1'b0; en0 = 1'b1;

    // First frame: landmark table and DE run statistics.
    wait_fs();
    cnt_de = 0; run_len = 0; max_run = 0; rises = 0;
    cur = 0;
    for (int k = 0; k < NVEC; k++) begin
      while (cur < tbl[k].off) begin step(); cur++; end
      chk("vec_de", k, int'(de[0]), int'(tbl[k].de));
      chk("vec_hs", k, int'(hs[0]), int'(tbl[k].hs));
      chk("vec_vs", k, int'(vs[0]), int'(tbl[k].vs));
      chk("vec_rgb", k, int'({r[0], g[0], b[0]}), int'(tbl[k].rgb));
    end
    while (cur < TOT - 1) begin step(); cur++; end
    chk("de_cycles", 0, cnt_de, HA * VA);
    chk("de_max_run", 0, max_run, HA);
    chk("de_lines", 0, rises, VA);

    // Second frame: pixel (5,3) goes missing.
    drop_tgt = 1'b1;
    step(); cur = 0;
    chk("uf_fs", 0, int'(fs[0]), 1);
    while (cur < 253) begin step(); cur++; end
    chk("uf_before", 0, int'(uf[0]), 0);
    step(); cur++;
    drop_tgt = 1'b0;
    chk("uf_rgb", 0, int'({r[0], g[0], b[0]}), int'(DEF0));
    chk("uf_set", 0, int'(uf[0]), 1);
    while (cur < TOT - 1) begin step(); cur++; end
    chk("uf_sticky", 0, int'(uf[0]), 1);
    step(); cur = 0;
    chk("uf_fs2", 0, int'(fs[0]), 1);
    chk("uf_at_fs", 0, int'(uf[0]), 1);
    step(); cur++;
    chk("uf_cleared", 0, int'(uf[0]), 0);

    // Third frame: drop en at line 10, the frame still completes.
    while (cur < HT * 10) begin step(); cur++; end
    en0 = 1'b0;
    while (cur < 5232) begin step(); cur++; end
    chk("stop_last_de", 0, int'(de[0]), 1);
    chk("stop_last_rgb", 0, int'({r[0], g[0], b[0]}), 24'h3F3F00);
    while (cur < TOT - 1) begin step(); cur++; end
    seen_fs = 1'b0; seen_req = 1'b0;
    repeat (300) begin
      step();
      seen_fs  |= fs[0];
      seen_req |= req[0];
    end
    chk("stop_no_fs", 0, int'(seen_fs), 0);
    chk("stop_no_req", 0, int'(seen_req), 0);
    en0 = 1'b1;
    step(); cur = 0;
    chk("restart_fs", 0, int'(fs[0]), 1);

    // Reset in the middle of active video.
    while (cur < HT * 5 + 10) begin step(); cur++; end
    rst = 1'b1;
    #1;
    chk("rst_de", 0, int'(de[0]), 0);
    chk("rst_hs", 0, int'(hs[0]), 1);
    chk("rst_vs", 0, int'(vs[0]), 1);
    chk("rst_hs_pol1", 1, int'(hs[1]), 0);
    chk("rst_rgb", 0, int'({r[0], g[0], b[0]}), 0);
    chk("rst_req", 0, int'(req[0]), 0);
    chk("rst_fs", 0, int'(fs[0]), 0);
    chk("rst_uf", 0, int'(uf[0]), 0);
    model_reset();
    check_all();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_fs", 0, int'(fs[0]), 1);
    chk("post_rst_x", 0, int'(px[0]), 0);
    chk("post_rst_y", 0, int'(py[0]), 0);
    repeat (2) begin
      step();
      chk("post_rst_de", 0, int'(de[0]), 0);
      chk("post_rst_rgb", 0, int'({r[0], g[0], b[0]}), 0);
    end

    // Random underflows and random run/stop requests.
    drop_rand = 1'b1;
    for (int n = 0; n < 3 * TOT; n++) begin
      if ($urandom_range(0, 999) == 0) en0 = !en0;
      step();
    end
    drop_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
